// File: rtl/tile_pkg.sv
// tile_pkg: shared constants, palette, sprite mask and tile-entry payload for tile_pixel_gen.
package tile_pkg;

    localparam int unsigned HLINES_DEF    = 640;
    localparam int unsigned VLINES_DEF    = 480;
    localparam int unsigned TILE_COLS_DEF = 40;
    localparam int unsigned MAP_AW_DEF    = 11;
    localparam int unsigned CNT_W         = 11;
    localparam int unsigned GLYPH_AW      = 9;
    localparam int unsigned PIX_W         = 8;
    localparam int unsigned SPR_W         = 10;
    localparam int unsigned SPR_SIZE      = 16;

    // Tile-map entry as delivered by the map RAM
    typedef struct packed {
        logic [1:0] pal;
        logic [5:0] glyph;
    } tile_entry_t;

    localparam logic [PIX_W-1:0] PALETTE [0:3] = '{8'h03, 8'hFF, 8'hE0, 8'h1C};
    localparam logic [PIX_W-1:0] BG_COLOUR     = 8'h00;
    localparam logic [PIX_W-1:0] SPRITE_COLOUR = 8'hFC;

    // Bit 15 is the leftmost sprite column; mouth opens to the right
    localparam logic [15:0] PACMAN_MASK [0:15] = '{
        16'b0000011111100000,
        16'b0001111111111000,
        16'b0011111111111100,
        16'b0111111111111110,
        16'b0111111111111000,
        16'b1111111111100000,
        16'b1111111110000000,
        16'b1111111100000000,
        16'b1111111110000000,
        16'b1111111111100000,
        16'b0111111111111000,
        16'b0111111111111110,
        16'b0011111111111100,
        16'b0001111111111000,
        16'b0000011111100000,
        16'b0000000000000000
    };

    function automatic logic glyph_bit(input logic [7:0] bits, input logic [2:0] gx);
        return bits[3'd7 - gx];
    endfunction

endpackage

// File: rtl/tile_pixel_gen_if.sv
// tile_pixel_gen_if: read bus towards the tile-map RAM and glyph ROM.
interface tile_pixel_gen_if;
    import tile_pkg::*;

    logic [MAP_AW_DEF-1:0] map_addr;
    logic [7:0]            map_data;
    logic [GLYPH_AW-1:0]   glyph_addr;
    logic [7:0]            glyph_data;

    modport master (output map_addr, output glyph_addr, input map_data, input glyph_data);
    modport slave  (input map_addr, input glyph_addr, output map_data, output glyph_data);
endinterface

// File: rtl/sync_delay.sv
// sync_delay: DEPTH-stage shift register for sync/blank, with a tap one stage before the end.
module sync_delay #(
    parameter int unsigned            DEPTH   = 4,
    parameter int unsigned            WIDTH   = 3,
    parameter logic [WIDTH-1:0]       RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_q_pre
);
    logic [WIDTH-1:0] r_sr [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) r_sr[i] <= RST_VAL;
        end else begin
            r_sr[0] <= i_d;
            for (int i = 1; i < int'(DEPTH); i++) r_sr[i] <= r_sr[i-1];
        end
    end

    assign o_q     = r_sr[DEPTH-1];
    assign o_q_pre = r_sr[DEPTH-2];
endmodule

// File: rtl/tile_pixel_gen.sv
// tile_pixel_gen: 4-stage tile/glyph renderer behind the VGA timing generator.
// Optional pacman sprite overlay is built when PACMAN_SPRITE_EN is defined.
module tile_pixel_gen
    import tile_pkg::*;
#(
    parameter int unsigned HLINES    = HLINES_DEF,
    parameter int unsigned VLINES    = VLINES_DEF,
    parameter int unsigned TILE_COLS = TILE_COLS_DEF,
    parameter int unsigned MAP_AW    = MAP_AW_DEF,
    parameter bit          SPP       = 1'b0
) (
    input  logic             pixel_clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] hcounter,
    input  logic [CNT_W-1:0] vcounter,
    input  logic             blank_in,
    input  logic             hs_in,
    input  logic             vs_in,
    tile_pixel_gen_if.master mem,
    input  logic [SPR_W-1:0] sprite_x,
    input  logic [SPR_W-1:0] sprite_y,
    output logic [PIX_W-1:0] rgb,
    output logic             hs_out,
    output logic             vs_out,
    output logic             blank_out
);
    logic              w_visible;
    logic [MAP_AW-1:0] w_map_addr;
    tile_entry_t       w_entry;
    logic [2:0]        r_gx0, r_gy0, r_gx1;
    logic [1:0]        r_pal1, r_pal2;
    logic              r_pix2;
    logic [2:0]        w_sync_q, w_sync_pre;
    logic              w_blank3;
    logic              w_spr_hit;
    logic [PIX_W-1:0]  w_rgb;

    assign w_visible  = (hcounter < CNT_W'(HLINES)) && (vcounter < CNT_W'(VLINES));
    assign w_map_addr = MAP_AW'(vcounter[8:4]) * MAP_AW'(TILE_COLS) + MAP_AW'(hcounter[9:4]);
    assign w_entry    = tile_entry_t'(mem.map_data);

    // S0 address, S1 glyph lookup, S2 pixel select, S3 colour
    always_ff @(posedge pixel_clk or negedge rst) begin
        if (!rst) begin
            mem.map_addr   <= '0;
            mem.glyph_addr <= '0;
            r_gx0          <= '0;
            r_gy0          <= '0;
            r_gx1          <= '0;
            r_pal1         <= '0;
            r_pal2         <= '0;
            r_pix2         <= 1'b0;
            rgb            <= '0;
        end else begin
            if (w_visible) mem.map_addr <= w_map_addr;
            r_gx0          <= hcounter[3:1];
            r_gy0          <= vcounter[3:1];
            mem.glyph_addr <= {w_entry.glyph, r_gy0};
            r_gx1          <= r_gx0;
            r_pal1         <= w_entry.pal;
            r_pix2         <= glyph_bit(mem.glyph_data, r_gx1);
            r_pal2         <= r_pal1;
            rgb            <= w_rgb;
        end
    end

    sync_delay #(
        .DEPTH   (4),
        .WIDTH   (3),
        .RST_VAL ({1'b1, ~SPP, ~SPP})
    ) u_sync_delay (
        .clk     (pixel_clk),
        .rst_n   (rst),
        .i_d     ({blank_in, vs_in, hs_in}),
        .o_q     (w_sync_q),
        .o_q_pre (w_sync_pre)
    );

    assign {blank_out, vs_out, hs_out} = w_sync_q;
    assign w_blank3 = w_sync_pre[2];

`ifdef PACMAN_SPRITE_EN
    logic [SPR_W-1:0] r_spr_x, r_spr_y;
    logic [CNT_W-1:0] w_dx, w_dy;
    logic             w_hit0;
    logic [2:0]       r_hit;

    assign w_dx   = hcounter - CNT_W'(r_spr_x);
    assign w_dy   = vcounter - CNT_W'(r_spr_y);
    // Visibility gate clips sprite pixels past the active area
    assign w_hit0 = w_visible && (w_dx < CNT_W'(SPR_SIZE)) && (w_dy < CNT_W'(SPR_SIZE))
                    && PACMAN_MASK[w_dy[3:0]][4'd15 - w_dx[3:0]];

    always_ff @(posedge pixel_clk or negedge rst) begin
        if (!rst) begin
            r_spr_x <= '0;
            r_spr_y <= '0;
            r_hit   <= '0;
        end else begin
            if (hcounter == '0 && vcounter == CNT_W'(VLINES)) begin
                r_spr_x <= sprite_x;
                r_spr_y <= sprite_y;
            end
            r_hit <= {r_hit[1:0], w_hit0};
        end
    end

    assign w_spr_hit = r_hit[2];
`else
    logic w_unused_sprite;
    assign w_unused_sprite = ^{sprite_x, sprite_y};
    assign w_spr_hit       = 1'b0;
`endif

    always_comb begin
        w_rgb = BG_COLOUR;
        if (w_blank3)       w_rgb = '0;
        else if (w_spr_hit) w_rgb = SPRITE_COLOUR;
        else if (r_pix2)    w_rgb = PALETTE[r_pal2];
    end
endmodule

// File: tb/tb_tile_pixel_gen.sv
// tb_tile_pixel_gen: directed checks of tile_pixel_gen against hand-computed pixels and sync timing.
module tb_tile_pixel_gen;
    logic        pixel_clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] hcounter = '0;
    logic [10:0] vcounter = '0;
    logic        blank_in = 1'b1;
    logic        hs_in = 1'b1;
    logic        vs_in = 1'b1;
    logic [9:0]  sprite_x = '0;
    logic [9:0]  sprite_y = '0;
    logic [7:0]  rgb;
    logic        hs_out, vs_out, blank_out;
    bit          force_ones = 1'b0;

    logic [7:0]  map_mem   [2048];
    logic [7:0]  glyph_mem [512];

    int n_tests = 0;
    int n_fail  = 0;
    int first_hs, first_bl, hs_low, bl_high, vs_low, bad_rgb, k;

    tile_pixel_gen_if bus ();

    assign bus.map_data   = force_ones ? 8'hFF : map_mem[bus.map_addr];
    assign bus.glyph_data = force_ones ? 8'hFF : glyph_mem[bus.glyph_addr];

    tile_pixel_gen dut (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .hcounter  (hcounter),
        .vcounter  (vcounter),
        .blank_in  (blank_in),
        .hs_in     (hs_in),
        .vs_in     (vs_in),
        .mem       (bus),
        .sprite_x  (sprite_x),
        .sprite_y  (sprite_y),
        .rgb       (rgb),
        .hs_out    (hs_out),
        .vs_out    (vs_out),
        .blank_out (blank_out)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one 640x480 VGA pixel (active-low syncs) and advance one clock
    task automatic apply(input int h, input int v);
        hcounter = 11'(h);
        vcounter = 11'(v);
        blank_in = (h >= 640) || (v >= 480);
        hs_in    = !((h >= 648) && (h < 744));
        vs_in    = !((v >= 490) && (v < 492));
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic px_check(input string tag, input int h, input int v, input logic [7:0] exp);
        for (int i = 0; i < 4; i++) apply(h, v);
        check_eq(tag, 32'(rgb), 32'(exp));
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) map_mem[i] = 8'h00;
        for (int i = 0; i < 512; i++)  glyph_mem[i] = 8'h00;
        map_mem[122]  = 8'h45;
        glyph_mem[41] = 8'b0010_0000;
        map_mem[0]    = 8'h83;
        glyph_mem[24] = 8'h80;
        map_mem[526]  = 8'hC2;
        for (int i = 16; i < 24; i++) glyph_mem[i] = 8'hFF;

        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            apply(37, 50);
            if (i == 0 || i == 9) begin
                check_eq("rst_rgb", 32'(rgb), 32'h00);
                check_eq("rst_blank", 32'(blank_out), 32'h1);
                check_eq("rst_hs", 32'(hs_out), 32'h1);
                check_eq("rst_vs", 32'(vs_out), 32'h1);
                check_eq("rst_map_addr", 32'(bus.map_addr), 32'h0);
                check_eq("rst_glyph_addr", 32'(bus.glyph_addr), 32'h0);
            end
        end
        rst = 1'b1;

        apply(37, 50);
        check_eq("map_addr_37_50", 32'(bus.map_addr), 32'd122);
        check_eq("blank_e1", 32'(blank_out), 32'h1);
        apply(36, 50);
        check_eq("glyph_addr", 32'(bus.glyph_addr), 32'h029);
        apply(38, 50);
        check_eq("blank_e3", 32'(blank_out), 32'h1);
        check_eq("rgb_e3", 32'(rgb), 32'h00);
        apply(0, 0);
        check_eq("rgb_37", 32'(rgb), 32'hFF);
        check_eq("blank_e4", 32'(blank_out), 32'h0);
        apply(0, 0);
        check_eq("rgb_36", 32'(rgb), 32'hFF);
        apply(0, 0);
        check_eq("rgb_38", 32'(rgb), 32'h00);

        px_check("rgb_0_0", 0, 0, 8'hE0);
        px_check("rgb_1_0", 1, 0, 8'hE0);
        px_check("rgb_2_0", 2, 0, 8'h00);

        apply(639, 479);
        check_eq("map_addr_last", 32'(bus.map_addr), 32'd1199);
        apply(640, 479);
        check_eq("map_addr_hold_h", 32'(bus.map_addr), 32'd1199);
        apply(0, 480);
        check_eq("map_addr_hold_v", 32'(bus.map_addr), 32'd1199);
        apply(0, 0);
        check_eq("map_addr_origin", 32'(bus.map_addr), 32'd0);

        // One full line with memories forced to all ones
        force_ones = 1'b1;
        first_hs = -1; first_bl = -1; hs_low = 0; bl_high = 0; vs_low = 0; bad_rgb = 0;
        for (int i = 0; i < 803; i++) begin
            if (i < 800) apply(i, 100);
            else         apply(i - 800, 101);
            if (i >= 3) begin
                k = i - 3;
                if (!hs_out) begin
                    hs_low++;
                    if (first_hs < 0) first_hs = k;
                end
                if (blank_out) begin
                    bl_high++;
                    if (first_bl < 0) first_bl = k;
                end
                if (!vs_out) vs_low++;
                if (rgb !== (blank_out ? 8'h00 : 8'h1C)) bad_rgb++;
            end
        end
        check_eq("hs_low_len", 32'(hs_low), 32'd96);
        check_eq("hs_first_pix", 32'(first_hs), 32'd648);
        check_eq("blank_len", 32'(bl_high), 32'd160);
        check_eq("blank_first_pix", 32'(first_bl), 32'd640);
        check_eq("vs_low_line", 32'(vs_low), 32'd0);
        check_eq("line_rgb_errs", 32'(bad_rgb), 32'd0);

        px_check("forced_visible", 639, 479, 8'h1C);
        px_check("forced_hblank", 640, 479, 8'h00);
        px_check("forced_vblank", 0, 480, 8'h00);
        px_check("forced_corner", 799, 524, 8'h00);
        force_ones = 1'b0;

        sprite_x = 10'd100;
        sprite_y = 10'd200;
        px_check("spr_midframe", 108, 208, 8'h1C);
        apply(0, 480);
`ifdef PACMAN_SPRITE_EN
        px_check("spr_hit", 108, 208, 8'hFC);
        sprite_x = 10'd632;
        apply(0, 480);
        px_check("spr_edge_hit", 639, 208, 8'hFC);
        px_check("spr_clipped", 640, 208, 8'h00);
        px_check("spr_moved_away", 108, 208, 8'h1C);
`else
        px_check("spr_ignored", 108, 208, 8'h1C);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
